rr_burst_arbiter: RTL
=====================

Name: rr_burst_arbiter

Overview:
- Round-robin arbiter with a burst-lock state machine.
- Shares one downstream valid/ready sink among NUM_REQ upstream requesters.
- A requester holds the grant until its packet ends, the burst cap is reached, or it stalls too long.
- Sits between the per-channel producers and the single shared consumer datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 16, payload width per beat.
- MAX_BURST, 8, maximum beats per grant (>=1).
- ABANDON_CYCLES, 4, consecutive cycles with the granted req_valid low that force release (>=1).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_last  input  NUM_REQ  per-requester last beat of packet.
- req_data  input  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-requester beat accepted.
- out_valid  output  1  beat valid to sink.
- out_data  output  DATA_WIDTH  muxed payload.
- out_src  output  clog2(NUM_REQ)  index of the granted requester.
- out_last  output  1  final beat of this grant.
- out_ready  input  1  sink accepts beat.
- grant  output  NUM_REQ  one-hot current grant; zero when idle.
- busy  output  1  high in LOCKED.

Behaviour:
- Reset state (rst_n low, takes effect immediately):
  - state=IDLE, grant=0, rr pointer=0, burst count=0, stall count=0.
  - All outputs 0.
  - A reset asserted mid-burst drops the burst; no beat completes.
- States: IDLE and LOCKED.
- IDLE:
  - Outputs are 0 and req_ready is all 0.
  - If any req_valid is high, select the first set bit scanning from the rr pointer upward, wrapping modulo NUM_REQ.
  - Register that one-hot as grant and move to LOCKED next cycle.
  - Arbitration latency: 1 cycle from req_valid to the first possible out_valid.
  - Set rr pointer to (winner+1) mod NUM_REQ.
- LOCKED, with g the granted index (combinational datapath):
  - out_valid = req_valid[g]; out_data = req_data[g]; out_src = g.
  - req_ready[g] = out_ready; all other req_ready bits are 0.
  - out_last = req_valid[g] & (req_last[g] | burst count==MAX_BURST-1).
- Beat accept (out_valid & out_ready):
  - Increment burst count and clear stall count.
  - If out_last is also high, go to IDLE next cycle and clear grant and burst count.
- Stall release:
  - A cycle with req_valid[g] low increments stall count.
  - When stall count reaches ABANDON_CYCLES-1 and req_valid[g] is still low, go to IDLE next cycle; no out_last is emitted.
- out_ready low with out_valid high: hold everything; stall count does not advance (the stall is downstream, not the requester's).
- One idle bubble follows every release. Re-arbitration in IDLE uses the updated pointer, so a requester that just released has the lowest priority.
- Requests from other requesters arriving during LOCKED are ignored until IDLE.
- The granted requester changing req_data while stalled is legal; it passes straight through.
- MAX_BURST=1: every accepted beat carries out_last.
- Counter widths:
  - burst count: clog2(MAX_BURST+1).
  - stall count: clog2(ABANDON_CYCLES+1).
  - Neither counter wraps; both are cleared on release.

Test Plan:
- Single requester 2 raises valid with a 3-beat packet (last on beat 3), out_ready=1.
  - grant=0100 one cycle later, out_src=2, three beats out, out_last on beat 3.
  - IDLE next cycle, rr pointer=3.
- All four requesters valid with continuous single-beat packets, pointer=0.
  - Grants in order 0,1,2,3,0, each separated by one idle cycle.
  - out_src sequence 0,1,2,3,0.
- Requester 1 streams 12 beats with no req_last, MAX_BURST=8.
  - out_last is forced on beat 8; release, then requester 1 is re-granted after the idle cycle.
  - The remaining 4 beats follow, with out_last on req_last.
- Granted requester 0 drops valid after 1 beat, ABANDON_CYCLES=4.
  - Release after 4 low cycles; no out_last; requester 3 (waiting) is granted next.
- Sink holds out_ready=0 for 10 cycles mid-burst.
  - No release, out_data stable, counters frozen.
  - The burst resumes when out_ready returns.
- Assert rst_n=0 mid-burst, asynchronous to the clock edge.
  - Outputs and grant are 0 immediately.
  - After release, first grant goes to the lowest-index valid requester (pointer=0).

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// ---------------------------------------------------------------------------
// rr_burst_arbiter
//
// Round-robin arbiter with burst lock. NUM_REQ upstream valid/ready
// producers share a single downstream sink. Once granted, a requester keeps
// the sink until its packet ends (req_last), the burst cap MAX_BURST is
// reached, or its req_valid stays low for ABANDON_CYCLES cycles. Every
// release is followed by one idle bubble, and re-arbitration starts one
// past the last winner so the releasing requester has the lowest priority.
//
// Ports
//   clock      : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : [NUM_REQ]            per-requester beat valid
//   req_last   : [NUM_REQ]            per-requester last beat of packet
//   req_data   : [NUM_REQ*DATA_WIDTH] packed payloads, requester i at
//                                     [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  : [NUM_REQ]            per-requester beat accepted
//   out_valid  : beat valid to sink
//   out_data   : [DATA_WIDTH] muxed payload of the granted requester
//   out_src    : [clog2(NUM_REQ)] index of the granted requester
//   out_last   : final beat of this grant
//   out_ready  : sink accepts beat
//   grant      : [NUM_REQ] one-hot grant, zero when idle
//   busy       : high while a grant is locked
// ---------------------------------------------------------------------------
module rr_burst_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int MAX_BURST      = 8,
    parameter int ABANDON_CYCLES = 4
) (
    input  logic                               clock,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               out_valid,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [$clog2(NUM_REQ)-1:0]         out_src,
    output logic                               out_last,
    input  logic                               out_ready,
    output logic [NUM_REQ-1:0]                 grant,
    output logic                               busy
);

    localparam int SRC_W   = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int STALL_W = $clog2(ABANDON_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               state_r,     state_n;
    logic [NUM_REQ-1:0]   grant_r,     grant_n;
    logic [SRC_W-1:0]     rr_ptr_r,    rr_ptr_n;
    logic [BURST_W-1:0]   burst_cnt_r, burst_n;
    logic [STALL_W-1:0]   stall_cnt_r, stall_n;

    logic                 win_found_s;
    logic [SRC_W-1:0]     win_idx_s;
    logic [NUM_REQ-1:0]   win_onehot_s;
    logic [SRC_W-1:0]     win_next_ptr_s;

    logic                 sel_valid_s;
    logic                 sel_last_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [SRC_W-1:0]     sel_src_s;
    logic                 burst_cap_s;
    logic                 accept_s;

    // Round-robin pick: scan offsets from highest to lowest so the smallest
    // offset from the pointer (highest priority) is the last one written.
    always_comb begin
        win_found_s = |req_valid;
        win_idx_s   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            win_idx_s = req_valid[(int'(rr_ptr_r) + off) % NUM_REQ]
                      ? SRC_W'((int'(rr_ptr_r) + off) % NUM_REQ)
                      : win_idx_s;
        end
        win_onehot_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
        win_next_ptr_s = (win_idx_s == SRC_W'(NUM_REQ - 1))
                       ? {SRC_W{1'b0}}
                       : win_idx_s + {{(SRC_W-1){1'b0}}, 1'b1};
    end

    // Granted-requester mux driven by the one-hot grant register.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = '0;
        sel_src_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_valid_s = sel_valid_s | (grant_r[i] & req_valid[i]);
            sel_last_s  = sel_last_s  | (grant_r[i] & req_last[i]);
            sel_data_s  = sel_data_s
                        | ({DATA_WIDTH{grant_r[i]}} & req_data[i*DATA_WIDTH +: DATA_WIDTH]);
            sel_src_s   = sel_src_s | (grant_r[i] ? SRC_W'(i) : {SRC_W{1'b0}});
        end
    end

    // Sink-side outputs: pass-through of the granted requester while locked.
    always_comb begin
        out_valid   = 1'b0;
        out_data    = '0;
        out_src     = '0;
        out_last    = 1'b0;
        req_ready   = '0;
        burst_cap_s = (burst_cnt_r == BURST_W'(MAX_BURST - 1));
        if (state_r == ST_LOCKED) begin
            out_valid = sel_valid_s;
            out_data  = sel_data_s;
            out_src   = sel_src_s;
            out_last  = sel_valid_s & (sel_last_s | burst_cap_s);
            req_ready = grant_r & {NUM_REQ{out_ready}};
        end else begin
            req_ready = '0;
        end
        accept_s = out_valid & out_ready;
    end

    assign grant = grant_r;
    assign busy  = (state_r == ST_LOCKED);

    // Next-state logic for the IDLE/LOCKED burst-lock machine.
    always_comb begin
        state_n  = state_r;
        grant_n  = grant_r;
        rr_ptr_n = rr_ptr_r;
        burst_n  = burst_cnt_r;
        stall_n  = stall_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_n  = ST_LOCKED;
                    grant_n  = win_onehot_s;
                    rr_ptr_n = win_next_ptr_s;
                    burst_n  = '0;
                    stall_n  = '0;
                end else begin
                    grant_n = '0;
                end
            end
            ST_LOCKED: begin
                if (accept_s) begin
                    stall_n = '0;
                    if (out_last) begin
                        state_n = ST_IDLE;
                        grant_n = '0;
                        burst_n = '0;
                    end else begin
                        burst_n = burst_cnt_r + {{(BURST_W-1){1'b0}}, 1'b1};
                    end
                end else if (!sel_valid_s) begin
                    // Requester-side stall; abandon on the last allowed cycle.
                    if (stall_cnt_r == STALL_W'(ABANDON_CYCLES - 1)) begin
                        state_n = ST_IDLE;
                        grant_n = '0;
                        burst_n = '0;
                        stall_n = '0;
                    end else begin
                        stall_n = stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    // Sink back-pressure: hold everything, stall count frozen.
                    stall_n = stall_cnt_r;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                grant_n  = '0;
                rr_ptr_n = '0;
                burst_n  = '0;
                stall_n  = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            rr_ptr_r    <= '0;
            burst_cnt_r <= '0;
            stall_cnt_r <= '0;
        end else begin
            state_r     <= state_n;
            grant_r     <= grant_n;
            rr_ptr_r    <= rr_ptr_n;
            burst_cnt_r <= burst_n;
            stall_cnt_r <= stall_n;
        end
    end

endmodule
